aq_spsram_128x8_ctrl: RTL and testbench
=======================================

Name: aq_spsram_128x8_ctrl

Overview:
- Sequencing and arbitration controller for one 128x8 single-port SRAM macro in the LSU.
- After reset, optionally zero-fills the whole array.
- Then shares the single port between two requesters (req0, req1) using round-robin.
- Drives the macro's active-low CEN/GWEN/WEN controls and returns read data with fixed one-cycle latency.

Parameters:
- ADDR_WIDTH, 7, SRAM address width (depth = 2^ADDR_WIDTH = 128).
- DATA_WIDTH, 8, SRAM data width and bit-write-mask width.
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = skip the fill.

Ports:
- CLK  input  1  Core clock; also clocks the SRAM macro.
- RST  input  1  Synchronous, active-high reset.
- reqN_vld  input  1  Request valid (N = 0, 1).
- reqN_wr  input  1  1 = write, 0 = read.
- reqN_addr  input  ADDR_WIDTH  Request address.
- reqN_wdata  input  DATA_WIDTH  Write data.
- reqN_wmask  input  DATA_WIDTH  Active-high bit-write enable.
- reqN_rdy  output  1  Request accepted this cycle.
- rspN_vld  output  1  Read data valid.
- rspN_rdata  output  DATA_WIDTH  Read data.
- init_done  output  1  Array ready for requests.
- sram_cen  output  1  SRAM chip enable, active-low.
- sram_gwen  output  1  SRAM global write enable, active-low.
- sram_wen  output  DATA_WIDTH  SRAM bit write enable, active-low.
- sram_a  output  ADDR_WIDTH  SRAM address.
- sram_d  output  DATA_WIDTH  SRAM write data.
- sram_q  input  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

Behaviour:
- States: INIT and RUN.
  - Any cycle with RST=1 forces: state=INIT (or RUN if INIT_EN=0), init counter=0, rr pointer=0, rsp pending cleared.
  - Outputs during RST=1: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0, reqN_rdy=0, rspN_vld=0, rspN_rdata=0, init_done=0.
- INIT state:
  - Each cycle: sram_cen=0, sram_gwen=0, sram_wen=0, sram_a=cnt, sram_d=0; cnt increments.
  - After the cnt=127 write, move to RUN. Exactly 128 write cycles.
  - reqN_rdy=0 throughout INIT.
  - init_done is registered; it goes 1 in the first RUN cycle and stays 1 until RST.
- INIT_EN=0: first cycle after RST deasserts is RUN with init_done=1; no fill.
- RUN arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester selected by the rr pointer (0 → req0, 1 → req1).
  - After any grant, the pointer moves to the other requester.
  - No grant: pointer holds.
- Grant is combinational, same cycle: reqN_rdy = grant to N. A request completes when vld & rdy.
- SRAM drive on a granted cycle (combinational from the grant):
  - sram_cen=0, sram_a=addr.
  - Write: sram_gwen=0, sram_wen=~wmask, sram_d=wdata.
  - Read: sram_gwen=1, sram_wen=all 1, sram_d=0.
- SRAM drive with no grant: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- Write with wmask=0 still performs a CEN access but changes no bits.
- Read response:
  - An accepted read sets a registered pending flag plus requester id.
  - Next cycle: rspN_vld=1 for that requester only, rspN_rdata=sram_q.
  - At all other times rspN_rdata=0.
  - Writes produce no response.
- Back-to-back reads: one per cycle, fully pipelined; both requesters may alternate every cycle.
- Responses are not back-pressured; requesters must accept them.
- Requester inputs are don't-care when vld=0.
- Reset mid-operation:
  - RST during INIT restarts the fill from address 0.
  - RST in the cycle after an accepted read suppresses that rspN_vld.

Test Plan:
- Fill: release RST with INIT_EN=1, hold req0_vld=1 → 128 consecutive cycles of cen=0/gwen=0/wen=0x00/d=0 with a=0..127; req0_rdy=0 until init_done=1 on cycle 129; a subsequent read of any address returns 0x00.
- Write/read: req0 write addr 0x15 data 0xA5 mask 0xFF, next cycle read 0x15 → rsp0_vld=1 one cycle after the read accept, rdata=0xA5; rsp1_vld stays 0.
- Bit mask: after the above, write addr 0x15 data 0x0F mask 0xF0, then read → rdata=0x05; sram_wen=0x0F during the write.
- Round-robin: both requesters issue reads every cycle for 6 cycles → grants alternate req0, req1, req0, ...; each rspN_vld is 1 exactly one cycle after its grant, with correct data.
- Reset mid-fill: assert RST for 1 cycle at cnt=50 → fill restarts at a=0; init_done rises only after a full 128 writes.
- INIT_EN=0: release RST with req1 read pending → req1_rdy=1 in the first post-reset cycle, init_done=1, no fill writes issued.

Source files
------------

// File: rtl/aq_spsram_128x8_ctrl.sv
// Sequencing/arbitration controller for a single-port 128x8 SRAM macro:
// optional post-reset zero fill, then round-robin sharing between two requesters.
module aq_spsram_128x8_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_rdy,
  output logic                  rsp0_vld,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_rdy,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    rr;
  logic                    pend, pend_id;
  logic                    init_done_q;
  logic                    gnt0, gnt1;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata, sel_wmask;

  assign sel_wr    = gnt1 ? req1_wr    : req0_wr;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  assign sel_wmask = gnt1 ? req1_wmask : req0_wmask;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    // Reset is synchronous, so the port must be forced idle while RST is high.
    if (!RST) begin
      case (state)
        S_INIT: begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = cnt;
          if (&cnt) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (req0_vld && (!req1_vld || !rr)) gnt0 = 1'b1;
          else if (req1_vld)                  gnt1 = 1'b1;
          if (gnt0 || gnt1) begin
            sram_cen = 1'b0;
            sram_a   = sel_addr;
            if (sel_wr) begin
              sram_gwen = 1'b0;
              sram_wen  = ~sel_wmask;
              sram_d    = sel_wdata;
            end
          end
        end
        default: state_nxt = RST_STATE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RST_STATE;
      cnt         <= '0;
      rr          <= 1'b0;
      pend        <= 1'b0;
      pend_id     <= 1'b0;
      init_done_q <= (INIT_EN == 0);
    end else begin
      state <= state_nxt;
      if (state == S_INIT) cnt <= cnt + ADDR_WIDTH'(1);
      if (state == S_INIT && (&cnt)) init_done_q <= 1'b1;
      if (gnt0) rr <= 1'b1;
      if (gnt1) rr <= 1'b0;
      pend    <= (gnt0 || gnt1) && !sel_wr;
      pend_id <= gnt1;
    end
  end

  assign req0_rdy   = gnt0;
  assign req1_rdy   = gnt1;
  assign init_done  = init_done_q && !RST;
  assign rsp0_vld   = pend && !pend_id && !RST;
  assign rsp1_vld   = pend &&  pend_id && !RST;
  assign rsp0_rdata = rsp0_vld ? sram_q : '0;
  assign rsp1_rdata = rsp1_vld ? sram_q : '0;

endmodule

// File: tb/tb_aq_spsram_128x8_ctrl.sv
// Scoreboard bench for aq_spsram_128x8_ctrl: a behavioural SRAM sits behind the
// INIT_EN=1 instance; a second INIT_EN=0 instance checks the no-fill start-up.
module tb_aq_spsram_128x8_ctrl;

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] wmask;
  } req_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         at;
  } exp_t;

  localparam req_t IDLE = '0;

  logic       CLK, RST;
  logic       req0_vld, req0_wr, req1_vld, req1_wr;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
  logic       req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, init_done;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       sram_cen, sram_gwen;
  logic [7:0] sram_wen, sram_d, sram_q;
  logic [6:0] sram_a;

  logic       n_rst, n_req1_vld;
  logic       n_req0_rdy, n_req1_rdy, n_rsp0_vld, n_rsp1_vld, n_init_done;
  logic [7:0] n_rsp0_rdata, n_rsp1_rdata, n_sram_wen, n_sram_d, n_sram_q;
  logic       n_sram_cen, n_sram_gwen;
  logic [6:0] n_sram_a;

  logic [7:0] mem [128];
  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  aq_spsram_128x8_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .INIT_EN(1)) u_dut (
    .CLK(CLK), .RST(RST),
    .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_rdy(req0_rdy),
    .rsp0_vld(rsp0_vld), .rsp0_rdata(rsp0_rdata),
    .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_rdy(req1_rdy),
    .rsp1_vld(rsp1_vld), .rsp1_rdata(rsp1_rdata),
    .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  aq_spsram_128x8_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .INIT_EN(0)) u_dut_noinit (
    .CLK(CLK), .RST(n_rst),
    .req0_vld(1'b0), .req0_wr(1'b0), .req0_addr(7'h00),
    .req0_wdata(8'h00), .req0_wmask(8'h00), .req0_rdy(n_req0_rdy),
    .rsp0_vld(n_rsp0_vld), .rsp0_rdata(n_rsp0_rdata),
    .req1_vld(n_req1_vld), .req1_wr(1'b0), .req1_addr(7'h33),
    .req1_wdata(8'h00), .req1_wmask(8'h00), .req1_rdy(n_req1_rdy),
    .rsp1_vld(n_rsp1_vld), .rsp1_rdata(n_rsp1_rdata),
    .init_done(n_init_done),
    .sram_cen(n_sram_cen), .sram_gwen(n_sram_gwen), .sram_wen(n_sram_wen),
    .sram_a(n_sram_a), .sram_d(n_sram_d), .sram_q(n_sram_q)
  );

  assign n_sram_q = 8'h6B;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural macro: active-low controls, bit-masked write, registered read data.
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the head of the scoreboard must appear exactly in its cycle.
  always @(negedge CLK) begin
    if (sb.size() > 0 && sb[0].at == cyc) begin
      check("rsp_vld", 32'({rsp1_vld, rsp0_vld}), (sb[0].id == 1) ? 32'h2 : 32'h1);
      check("rsp_rdata", 32'({rsp1_rdata, rsp0_rdata}),
            (sb[0].id == 1) ? 32'({sb[0].data, 8'h00}) : 32'({8'h00, sb[0].data}));
      void'(sb.pop_front());
    end else if (rsp0_vld || rsp1_vld) begin
      check("rsp_unexpected", 32'({rsp1_vld, rsp0_vld}), 32'h0);
    end
  end

  function automatic req_t mk(input logic wr, input logic [6:0] addr,
                              input logic [7:0] wdata, input logic [7:0] wmask);
    return '{vld: 1'b1, wr: wr, addr: addr, wdata: wdata, wmask: wmask};
  endfunction

  task automatic apply(input req_t r0, input req_t r1);
    req0_vld = r0.vld; req0_wr = r0.wr; req0_addr = r0.addr;
    req0_wdata = r0.wdata; req0_wmask = r0.wmask;
    req1_vld = r1.vld; req1_wr = r1.wr; req1_addr = r1.addr;
    req1_wdata = r1.wdata; req1_wmask = r1.wmask;
  endtask

  // One RUN cycle: check grant and macro drive, queue the expected read response.
  task automatic step(input req_t r0, input req_t r1, input logic [1:0] exp_gnt,
                      input logic [7:0] exp_rd, input bit push);
    req_t g;
    apply(r0, r1);
    @(negedge CLK);
    check("grant", 32'({req1_rdy, req0_rdy}), 32'(exp_gnt));
    if (exp_gnt != 2'b00) begin
      g = exp_gnt[1] ? r1 : r0;
      check("sram_drive", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            32'({1'b0, ~g.wr, g.wr ? ~g.wmask : 8'hFF, g.addr, g.wr ? g.wdata : 8'h00}));
      if (!g.wr && push) sb.push_back('{id: exp_gnt[1] ? 1 : 0, data: exp_rd, at: cyc + 1});
    end else begin
      check("sram_idle", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            32'({1'b1, 1'b1, 8'hFF, 7'h00, 8'h00}));
    end
    @(posedge CLK); #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("fill", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req0_rdy, init_done}),
            32'({1'b0, 1'b0, 8'h00, 7'(i), 8'h00, 1'b0, 1'b0}));
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_reset_idle(input string name);
    @(negedge CLK);
    check(name, 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
                     req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, init_done}),
          32'({1'b1, 1'b1, 8'hFF, 7'h00, 8'h00, 5'b00000}));
    check({name, "_rdata"}, 32'({rsp1_rdata, rsp0_rdata}), 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    n_rst = 1'b1;
    n_req1_vld = 1'b1;
    apply(mk(1'b0, 7'h00, 8'h00, 8'h00), IDLE);
    repeat (2) @(posedge CLK);
    #1;
    check_reset_idle("reset_state");
    check("noinit_in_reset", 32'({n_req1_rdy, n_init_done, n_sram_cen}), 32'h1);
    @(posedge CLK); #1;

    // Fill, reset at cnt=50, then a complete uninterrupted fill.
    RST = 1'b0;
    fill(50);
    RST = 1'b1;
    check_reset_idle("reset_mid_fill");
    @(posedge CLK); #1;
    RST = 1'b0;
    fill(128);

    step(mk(1'b0, 7'h44, 8'h00, 8'h00), IDLE, 2'b01, 8'h00, 1'b1);
    check("init_done", 32'(init_done), 32'h1);

    step(mk(1'b1, 7'h15, 8'hA5, 8'hFF), IDLE, 2'b01, 8'h00, 1'b0);
    step(mk(1'b0, 7'h15, 8'h00, 8'h00), IDLE, 2'b01, 8'hA5, 1'b1);
    step(mk(1'b1, 7'h15, 8'h0F, 8'hF0), IDLE, 2'b01, 8'h00, 1'b0);
    step(mk(1'b0, 7'h15, 8'h00, 8'h00), IDLE, 2'b01, 8'h05, 1'b1);
    step(IDLE, mk(1'b1, 7'h20, 8'h3C, 8'hFF), 2'b10, 8'h00, 1'b0);

    // Both requesters read every cycle: grants alternate starting with req0.
    for (int k = 0; k < 6; k++)
      step(mk(1'b0, 7'h15, 8'h00, 8'h00), mk(1'b0, 7'h20, 8'h00, 8'h00),
           (k % 2 == 1) ? 2'b10 : 2'b01, (k % 2 == 1) ? 8'h3C : 8'h05, 1'b1);

    step(IDLE, mk(1'b1, 7'h20, 8'hFF, 8'h00), 2'b10, 8'h00, 1'b0);
    step(IDLE, mk(1'b0, 7'h20, 8'h00, 8'h00), 2'b10, 8'h3C, 1'b1);
    step(IDLE, IDLE, 2'b00, 8'h00, 1'b0);

    // Reset in the cycle after an accepted read drops the response.
    step(mk(1'b0, 7'h15, 8'h00, 8'h00), IDLE, 2'b01, 8'h05, 1'b0);
    apply(IDLE, IDLE);
    RST = 1'b1;
    check_reset_idle("reset_after_read");
    @(posedge CLK); #1;

    // INIT_EN=0 instance: read accepted in the first cycle out of reset.
    n_rst = 1'b0;
    @(negedge CLK);
    check("noinit_first", 32'({n_req1_rdy, n_req0_rdy, n_init_done, n_sram_cen, n_sram_gwen, n_sram_a}),
          32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'h33}));
    @(posedge CLK); #1;
    n_req1_vld = 1'b0;
    @(negedge CLK);
    check("noinit_rsp", 32'({n_rsp1_vld, n_rsp0_vld, n_rsp1_rdata, n_rsp0_rdata, n_sram_cen, n_init_done}),
          32'({1'b1, 1'b0, 8'h6B, 8'h00, 1'b1, 1'b1}));
    @(posedge CLK); #1;

    @(negedge CLK);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
